// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-requester memory arbiter.
// ARCH_SIZE normally comes from conf.sv; the guarded fallback keeps this package
// self-contained when it is compiled before conf.sv.
`ifndef ARCH_SIZE
`define ARCH_SIZE 16
`endif

package mem_arb_pkg;

    localparam int ARCH_W = `ARCH_SIZE;
    localparam int MEM_ARB_DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    // Index of a requester: 0 = instruction fetch, 1 = load/store.
    typedef logic req_idx_t;

    function automatic logic [1:0] idx_to_onehot(input req_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/conf.sv
// Project-wide build configuration shared by the CPU core and its memory-side blocks.
// ARCH_SIZE is the address width of the memory port.
`ifndef ARCH_SIZE
`define ARCH_SIZE 16
`endif

// File: rtl/mem_arb_rr_picker.sv
// mem_arb_rr_picker: combinational round-robin choice between two requesters.
// When both request, the one that was not served last wins.
module mem_arb_rr_picker
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last,
    output logic       valid,
    output req_idx_t   winner
);

    // Single requester wins outright; a tie goes to the requester other than last.
    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (requester 0)
// and load/store (requester 1). Requests are held levels; one transaction runs
// at a time through IDLE -> WAIT -> DONE, and every output is a flop.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (abort a WAIT that lasts
// TIMEOUT_CYCLES cycles, reporting err = 1 with done).
//
// Memory handshake: mem_read/mem_write, mem_address and mem_write_value are
// presented together and held unchanged until mem_ready is sampled high on a
// rising edge; that edge completes the access, and mem_read_value is taken on it.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_ARB_DEFAULT_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        req_write,
    input  logic [ARCH_W-1:0] req_address0,
    input  logic [ARCH_W-1:0] req_address1,
    input  logic [7:0]        req_wdata0,
    input  logic [7:0]        req_wdata1,
    output logic [1:0]        done,
    output logic              err,
    output logic [7:0]        rdata,
    output logic [1:0]        grant,
    output logic [ARCH_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [7:0]        mem_write_value,
    input  logic [7:0]        mem_read_value,
    input  logic              mem_ready,
    output arb_state_e        dbg_state
);

    arb_state_e        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [ARCH_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    req_idx_t          last_q, last_d;

    logic              pick_valid;
    req_idx_t          pick_winner;

    mem_arb_rr_picker u_picker (
        .req    (req),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;

    // Count WAIT cycles; the counter sits at zero outside WAIT so it is clear on entry.
    always_comb begin
        cnt_d       = (state_q == ARB_WAIT) ? cnt_q + 1'b1 : '0;
        timeout_hit = (state_q == ARB_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Timeout counter register.
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // Next-state and output decode for the IDLE/WAIT/DONE sequence.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = 2'b00;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d = idx_to_onehot(pick_winner);
                    addr_d  = pick_winner ? req_address1 : req_address0;
                    wdata_d = pick_winner ? req_wdata1 : req_wdata0;
                    rd_d    = ~req_write[pick_winner];
                    wr_d    = req_write[pick_winner];
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (mem_ready) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (rd_q) rdata_d = mem_read_value;
                    done_d  = grant_q;
                    last_d  = grant_q[1];
                    state_d = ARB_DONE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rdata_d = 8'h00;
                    done_d  = grant_q;
                    err_d   = 1'b1;
                    last_d  = grant_q[1];
                    state_d = ARB_DONE;
                end
`endif
            end
            ARB_DONE: begin
                // done is high only in this state; requests are not looked at here.
                grant_d = 2'b00;
                state_d = ARB_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            last_q  <= last_d;
        end
    end

    assign done            = done_q;
    assign err             = err_q;
    assign rdata           = rdata_q;
    assign grant           = grant_q;
    assign mem_address     = addr_q;
    assign mem_read        = rd_q;
    assign mem_write       = wr_q;
    assign mem_write_value = wdata_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and randomized checks of mem_arbiter, with
// hand-written sequences for reset mid-transaction, stray mem_ready and timeout.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 16;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]        req = 2'b00;
  logic [1:0]        req_write = 2'b00;
  logic [ARCH_W-1:0] req_address0 = '0;
  logic [ARCH_W-1:0] req_address1 = '0;
  logic [7:0]        req_wdata0 = 8'h00;
  logic [7:0]        req_wdata1 = 8'h00;
  logic [1:0]        done;
  logic              err;
  logic [7:0]        rdata;
  logic [1:0]        grant;
  logic [ARCH_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [7:0]        mem_write_value;
  logic [7:0]        mem_read_value = 8'h00;
  logic              mem_ready = 1'b0;
  arb_state_e        dbg_state;

  mem_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .req(req), .req_write(req_write),
    .req_address0(req_address0), .req_address1(req_address1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .done(done), .err(err), .rdata(rdata), .grant(grant),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_value(mem_write_value), .mem_read_value(mem_read_value),
    .mem_ready(mem_ready), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  // Reference model state: who was served last, and the byte rdata holds.
  logic       model_last = 1'b1;
  logic [7:0] model_rdata = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 2'b00;
    mem_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    model_last = 1'b1;
    model_rdata = 8'h00;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".done"}, 32'(done), 0);
    chk({name, ".err"}, 32'(err), 0);
    chk({name, ".rdata"}, 32'(rdata), 0);
    chk({name, ".grant"}, 32'(grant), 0);
    chk({name, ".addr"}, 32'(mem_address), 0);
    chk({name, ".rd"}, 32'(mem_read), 0);
    chk({name, ".wr"}, 32'(mem_write), 0);
    chk({name, ".wval"}, 32'(mem_write_value), 0);
    chk({name, ".state"}, 32'(dbg_state), 32'(ARB_IDLE));
  endtask

  // ---------------- driver ----------------
  // One complete transaction: present r, wait `delay` WAIT edges, then ready
  // (or no ready at all when timeout is set), and check every phase.
  task automatic do_txn(input string name, input logic [1:0] r, input logic [1:0] w,
                        input logic [ARCH_W-1:0] a0, input logic [ARCH_W-1:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input int delay, input logic [7:0] mval, input bit timeout,
                        input logic ew, input logic [7:0] er);
    logic [1:0]        eg;
    logic [ARCH_W-1:0] ea;
    logic [7:0]        ed;
    eg = ew ? 2'b10 : 2'b01;
    ea = ew ? a1 : a0;
    ed = ew ? d1 : d0;
    req_write = w;
    req_address0 = a0;
    req_address1 = a1;
    req_wdata0 = d0;
    req_wdata1 = d1;
    mem_ready = 1'b0;
    req = r;
    step();
    for (int i = 0; i < delay; i++) begin
      chk({name, ".grant"}, 32'(grant), 32'(eg));
      chk({name, ".rd"}, 32'(mem_read), 32'(!w[ew]));
      chk({name, ".wr"}, 32'(mem_write), 32'(w[ew]));
      chk({name, ".addr"}, 32'(mem_address), 32'(ea));
      chk({name, ".wval"}, 32'(mem_write_value), 32'(ed));
      chk({name, ".busy_done"}, 32'(done), 0);
      if (i == delay - 1 && !timeout) begin
        mem_ready = 1'b1;
        mem_read_value = mval;
      end
      step();
      mem_ready = 1'b0;
      mem_read_value = 8'h00;
    end
    exp_q.push_back(er);
    chk({name, ".done"}, 32'(done), 32'(eg));
    chk({name, ".err"}, 32'(err), 32'(timeout));
    chk({name, ".rdata"}, 32'(rdata), 32'(exp_q.pop_front()));
    chk({name, ".strobe_off"}, 32'({mem_read, mem_write}), 0);
    chk({name, ".grant_held"}, 32'(grant), 32'(eg));
    req = 2'b00;
    step();
    chk({name, ".done_1cyc"}, 32'(done), 0);
    chk({name, ".grant_clr"}, 32'(grant), 0);
    chk({name, ".idle"}, 32'(dbg_state), 32'(ARB_IDLE));
    model_last = ew;
    model_rdata = er;
  endtask

  // Round-robin rule: a single requester wins; a tie goes to the one not served last.
  function automatic logic rr_winner(input logic [1:0] r);
    return (r == 2'b11) ? ~model_last : r[1];
  endfunction

  // ---------------- vectors ----------------
  typedef struct {
    bit               rst;
    logic [1:0]       r;
    logic [1:0]       w;
    logic [ARCH_W-1:0] a0;
    logic [ARCH_W-1:0] a1;
    logic [7:0]       d0;
    logic [7:0]       d1;
    int               delay;
    logic [7:0]       mval;
    logic             ew;
    logic [7:0]       er;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 2'b01, 2'b00, 'h0004, 'h0000, 8'h00, 8'h00, 1, 8'hA5, 1'b0, 8'hA5};
    tbl[1] = '{1'b1, 2'b11, 2'b00, 'h0020, 'h0030, 8'h00, 8'h00, 1, 8'h11, 1'b0, 8'h11};
    tbl[2] = '{1'b0, 2'b11, 2'b00, 'h0020, 'h0030, 8'h00, 8'h00, 2, 8'h22, 1'b1, 8'h22};
    tbl[3] = '{1'b0, 2'b11, 2'b00, 'h0020, 'h0030, 8'h00, 8'h00, 1, 8'h33, 1'b0, 8'h33};
    tbl[4] = '{1'b0, 2'b11, 2'b00, 'h0020, 'h0030, 8'h00, 8'h00, 3, 8'h44, 1'b1, 8'h44};
    tbl[5] = '{1'b0, 2'b10, 2'b10, 'h0000, 'h0010, 8'h00, 8'h3C, 5, 8'h99, 1'b1, 8'h44};
    tbl[6] = '{1'b0, 2'b01, 2'b01, 'h0055, 'h0000, 8'h5A, 8'h00, 2, 8'h98, 1'b0, 8'h44};
    tbl[7] = '{1'b0, 2'b11, 2'b01, 'h0066, 'h0077, 8'h12, 8'h00, 1, 8'h77, 1'b1, 8'h77};
  end

  // Watchdog: the test is a fixed number of cycles; anything far beyond is a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    logic [1:0]        rr;
    logic [1:0]        rw;
    logic [ARCH_W-1:0] ra0;
    logic [ARCH_W-1:0] ra1;
    logic [7:0]        rd0;
    logic [7:0]        rd1;
    logic [7:0]        rmv;
    logic              ew;
    int                dly;

    do_reset();
    chk_all_zero("reset");

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rst) do_reset();
      do_txn($sformatf("vec%0d", i), tbl[i].r, tbl[i].w, tbl[i].a0, tbl[i].a1,
             tbl[i].d0, tbl[i].d1, tbl[i].delay, tbl[i].mval, 1'b0, tbl[i].ew, tbl[i].er);
    end

    // Stray mem_ready while idle: no done, rdata and last untouched.
    req = 2'b00;
    mem_ready = 1'b1;
    mem_read_value = 8'hEE;
    step();
    mem_ready = 1'b0;
    chk("idle_ready.done", 32'(done), 0);
    chk("idle_ready.grant", 32'(grant), 0);
    chk("idle_ready.rdata", 32'(rdata), 32'(model_rdata));
    step();
    chk("idle_ready.done2", 32'(done), 0);
    do_txn("after_idle_ready", 2'b11, 2'b00, 'h0101, 'h0202, 8'h00, 8'h00, 1, 8'h5C,
           1'b0, rr_winner(2'b11), 8'h5C);

    // Reset while in WAIT, then a late mem_ready.
    req_write = 2'b00;
    req_address0 = 'h0040;
    req = 2'b01;
    step();
    chk("rst_wait.in_wait", 32'(dbg_state), 32'(ARB_WAIT));
    reset = 1'b1;
    step();
    chk_all_zero("rst_wait");
    reset = 1'b0;
    req = 2'b00;
    model_last = 1'b1;
    model_rdata = 8'h00;
    mem_ready = 1'b1;
    mem_read_value = 8'hC3;
    step();
    mem_ready = 1'b0;
    chk_all_zero("late_ready");
    step();
    chk_all_zero("late_ready2");
    do_txn("after_rst_wait", 2'b11, 2'b00, 'h0008, 'h0009, 8'h00, 8'h00, 1, 8'h3E,
           1'b0, 1'b0, 8'h3E);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never readies: abort after TB_TIMEOUT WAIT cycles, err = 1, rdata = 0.
    do_txn("timeout", 2'b10, 2'b00, 'h0000, 'h0abc, 8'h00, 8'h00, TB_TIMEOUT, 8'h00,
           1'b1, 1'b1, 8'h00);
    do_txn("after_timeout", 2'b01, 2'b00, 'h0def, 'h0000, 8'h00, 8'h00, 2, 8'h6B,
           1'b0, 1'b0, 8'h6B);
    // Ready on the same edge as expiry completes normally.
    do_txn("ready_at_expiry", 2'b11, 2'b00, 'h0011, 'h0022, 8'h00, 8'h00, TB_TIMEOUT, 8'h2D,
           1'b0, rr_winner(2'b11), 8'h2D);
`endif

    // Randomized traffic against the round-robin / rdata-hold model.
    for (int i = 0; i < 24; i++) begin
      rr  = 2'($urandom_range(1, 3));
      rw  = 2'($urandom_range(0, 3));
      ra0 = ARCH_W'($urandom);
      ra1 = ARCH_W'($urandom);
      rd0 = 8'($urandom);
      rd1 = 8'($urandom);
      rmv = 8'($urandom);
      dly = $urandom_range(1, 3);
      ew  = rr_winner(rr);
      do_txn($sformatf("rand%0d", i), rr, rw, ra0, ra1, rd0, rd1, dly, rmv, 1'b0, ew,
             rw[ew] ? model_rdata : rmv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Both grant bits must never be set together.
  always @(negedge clock) begin
    if (!reset && grant == 2'b11) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_onehot: got 0x%0h expected at most one bit at %0t", grant, $time);
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single memory port between the CPU's instruction-fetch path (requester 0) and its load/store path (requester 1). It accepts held-level requests, grants one at a time with round-robin priority, drives the memory read/write handshake, waits for `mem_ready`, and returns the read byte with a one-cycle `done` pulse. It sits between the CPU core and the memory model, replacing the core's direct ownership of `read`/`address`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: cycles in WAIT before abort; used only with `MEM_ARB_TIMEOUT_EN`.

Ports:
- `clock`  in  1  rising-edge system clock.
- `reset`  in  1  synchronous, active-high reset.
- `req[1:0]`  in  2  per-requester request level; held high until that requester's `done`.
- `req_write[1:0]`  in  2  per-requester: 1 = write, 0 = read.
- `req_address0`, `req_address1`  in  `ARCH_SIZE` each  request addresses.
- `req_wdata0`, `req_wdata1`  in  8 each  write data.
- `done[1:0]`  out  2  one-cycle completion pulse, at most one bit set.
- `err`  out  1  valid with `done`; 1 = aborted by timeout.
- `rdata`  out  8  read byte; valid with `done` for reads.
- `grant[1:0]`  out  2  one-hot owner of the memory port, 0 when idle.
- `mem_address`  out  `ARCH_SIZE`  memory address.
- `mem_read`, `mem_write`  out  1 each  command strobes, held until `mem_ready`.
- `mem_write_value`  out  8  write data.
- `mem_read_value`  in  8  read data, sampled when `mem_ready` = 1.
- `mem_ready`  in  1  completion from memory, sampled synchronously.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: if any `req` bit is set, pick a winner (round-robin: prefer requester ≠ `last`; with a single requester it wins). Latch its address, write flag and wdata. Set `grant`, assert `mem_read` or `mem_write`, and go to WAIT. With no request, stay in IDLE and hold all strobes low.
- WAIT: hold `mem_address`, the strobe and `mem_write_value` stable. On `mem_ready`:
  - drop the strobe;
  - for reads, capture `mem_read_value` into `rdata`;
  - set `done[winner]`, `err` = 0;
  - set `last` = winner;
  - go to DONE.
- DONE: `done` is high for exactly this cycle. `grant` clears on exit. Go to IDLE.
- Requester contract: drop `req` (or present a new request) on the edge after `done` is seen. The arbiter does not sample `req` in DONE.
- `req` dropped during WAIT: the transaction still completes and `done` still pulses.
- `mem_ready` in IDLE or DONE: ignored.
- Reset, including mid-transaction:
  - state = IDLE; `grant`, `done`, `err`, `mem_read`, `mem_write` = 0;
  - `mem_address`, `mem_write_value`, `rdata` = 0;
  - `last` = 1, so requester 0 wins the first tie;
  - any in-flight memory operation is abandoned, and a late `mem_ready` is ignored.

## Timing
- Request seen high at edge N (state IDLE). Strobe and `grant` are registered high after N.
- `mem_ready` sampled high at edge M. `done` and `rdata` are registered high after M and held for one cycle.
- Request-to-done latency = (M − N) + 1 edges. With a zero-wait memory (`mem_ready` on the first WAIT edge), `done` is visible 2 cycles after the request is sampled.
- Minimum 3 cycles per transaction (IDLE, WAIT, DONE). Back-to-back alternating requests are therefore serviced every 3 cycles.
- All outputs are registered. There is no combinational path from `req` or `mem_ready` to any output.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - a counter clears on entry to WAIT and increments each WAIT cycle;
  - if it reaches `TIMEOUT_CYCLES` without `mem_ready`, drop the strobe, pulse `done[winner]` with `err` = 1 and `rdata` = 0, set `last`, and go to DONE;
  - `mem_ready` on the same edge as expiry wins (normal completion, `err` = 0).
- Not defined: WAIT lasts indefinitely, `err` is tied 0, and no counter is instantiated.

## Structure
- Package `mem_arb_pkg`:
  - state enum (`ARB_IDLE`, `ARB_WAIT`, `ARB_DONE`);
  - requester-index typedef (1 bit);
  - `MEM_ARB_DEFAULT_TIMEOUT` = 16.
- Width comes from `ARCH_SIZE` in `conf.sv`.
- Sub-module `mem_arb_rr_picker`: combinational; inputs `req[1:0]` and `last`; outputs `valid` and `winner`. Instantiated once, in IDLE decode.

## Test plan
- Reset, then `req`=01 for a read at 0x0004, memory returns 0xA5 with ready on the 1st WAIT cycle → `mem_read` high 1 cycle, `done`=01, `rdata`=0xA5, `err`=0, total 3 cycles.
- `req`=11 simultaneously after reset, repeated → grants in order 0, 1, 0, 1; no cycle with both `grant` bits set.
- Requester 1 writes 0x3C to 0x0010, memory delays ready by 5 cycles → `mem_write`, `mem_address`=0x0010 and `mem_write_value`=0x3C are held stable for 5 cycles; `done`=10.
- `reset` asserted in WAIT, then `mem_ready` pulses → all outputs 0 next cycle, no `done`, state IDLE.
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, memory never readies → `done` with `err`=1 after 4 WAIT cycles. A subsequent request from the other requester is serviced normally.
- `mem_ready` pulsed while IDLE with no request → no `done`, and no change to `rdata` or `last`.
